// File: rtl/regex_instr_memory_arbiter.sv
`default_nettype none
// ============================================================================
// regex_instr_memory_arbiter : round-robin shared instruction RAM for regex CPUs
//                              with a priority program-load write port
// Revision 1.0
// ============================================================================
module regex_instr_memory_arbiter #(
  parameter int N_PORTS           = 4,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_PORTS-1:0]                   mem_valid,
  input  logic [N_PORTS*MEMORY_ADDR_WIDTH-1:0] mem_addr,
  output logic [N_PORTS-1:0]                   mem_ready,
  output logic [N_PORTS*MEMORY_WIDTH-1:0]      mem_data,
  input  logic                                 load_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0]         load_addr,
  input  logic [MEMORY_WIDTH-1:0]              load_data,
  output logic                                 load_ready
);

  localparam int AW    = MEMORY_ADDR_WIDTH;
  localparam int MW    = MEMORY_WIDTH;
  localparam int PW    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int DEPTH = 2 ** AW;

  logic [MW-1:0]      ram_q [DEPTH];
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [MW-1:0]      rdata_q, rdata_d;
  logic [N_PORTS-1:0] grant;
  logic               grant_any;
  logic               rd_en;
  logic [AW-1:0]      rd_addr;
  logic [PW-1:0]      ptr_next;

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    rd_addr   = '0;
    ptr_next  = rr_ptr_q;
    // Pass one covers ports at or above the pointer, pass two wraps to port 0.
    for (int i = 0; i < N_PORTS; i++) begin
      if (!grant_any && mem_valid[i] && (i >= int'(rr_ptr_q))) begin
        grant_any = 1'b1;
        grant[i]  = 1'b1;
        rd_addr   = mem_addr[i*AW +: AW];
        ptr_next  = (i == N_PORTS - 1) ? '0 : PW'(i + 1);
      end
    end
    for (int i = 0; i < N_PORTS; i++) begin
      if (!grant_any && mem_valid[i]) begin
        grant_any = 1'b1;
        grant[i]  = 1'b1;
        rd_addr   = mem_addr[i*AW +: AW];
        ptr_next  = (i == N_PORTS - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  // A loader write owns the single RAM port for the cycle.
  assign rd_en      = grant_any & ~load_valid & ~rst;
  assign mem_ready  = rd_en ? grant : '0;
  assign load_ready = load_valid & ~rst;

  always_comb begin
    rdata_d  = rdata_q;
    rr_ptr_d = rr_ptr_q;
    if (rd_en) begin
      rdata_d  = ram_q[rd_addr];
      rr_ptr_d = ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      rdata_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_ready) begin
      ram_q[load_addr] <= load_data;
    end
  end

  generate
    for (genvar i = 0; i < N_PORTS; i++) begin : g_data
      assign mem_data[i*MW +: MW] = rdata_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regex_instr_memory_arbiter.sv
`default_nettype none
// ============================================================================
// tb_regex_instr_memory_arbiter : scoreboard bench for the shared instruction RAM
// Revision 1.0
// ============================================================================
module tb_regex_instr_memory_arbiter;

  localparam int N  = 4;
  localparam int MW = 16;
  localparam int AW = 11;
  localparam int PW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    mem_valid;
  logic [N*AW-1:0] mem_addr;
  logic [N-1:0]    mem_ready;
  logic [N*MW-1:0] mem_data;
  logic            load_valid;
  logic [AW-1:0]   load_addr;
  logic [MW-1:0]   load_data;
  logic            load_ready;

  regex_instr_memory_arbiter #(
    .N_PORTS          (N),
    .MEMORY_WIDTH     (MW),
    .MEMORY_ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_data  (mem_data),
    .load_valid(load_valid),
    .load_addr (load_addr),
    .load_data (load_data),
    .load_ready(load_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  rdy;
    logic          lr;
    logic [MW-1:0] data;
  } exp_t;

  exp_t          cyc_q[$];
  logic [MW-1:0] resp_q[$];

  // Reference model: plain RAM array, integer pointer, last read value.
  logic [MW-1:0] ram_m [0:(1<<AW)-1];
  logic [MW-1:0] m_rdata = '0;
  int            m_ptr   = 0;
  int            last_g  = -1;

  int total = 0;
  int bad   = 0;

  function automatic logic [N*AW-1:0] addrs(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  // Drive one clock cycle of stimulus and push what the DUT must show during it.
  task automatic step(input logic r, input logic [N-1:0] v, input logic [N*AW-1:0] a,
                      input logic lv, input logic [AW-1:0] la, input logic [MW-1:0] ld);
    exp_t e;
    int   g;
    int   idx;
    @(posedge clk);
    #1;
    rst        = r;
    mem_valid  = v;
    mem_addr   = a;
    load_valid = lv;
    load_addr  = la;
    load_data  = ld;
    e.rdy  = '0;
    e.lr   = lv & ~r;
    e.data = m_rdata;
    last_g = -1;
    if (r) begin
      m_rdata = '0;
      m_ptr   = 0;
    end else if (lv) begin
      ram_m[la] = ld;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && v[PW'(idx)]) g = idx;
      end
      if (g >= 0) begin
        e.rdy[PW'(g)] = 1'b1;
        m_rdata = ram_m[a[g*AW +: AW]];
        resp_q.push_back(m_rdata);
        m_ptr  = (g + 1) % N;
        last_g = g;
      end
    end
    cyc_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic load(input int la, input int ld);
    step(1'b0, '0, '0, 1'b1, AW'(la), MW'(ld));
  endtask

  // Monitor: per-cycle expectations, plus fetch responses the cycle after each grant.
  initial begin
    logic [N-1:0]  prev_rdy;
    logic [MW-1:0] want;
    exp_t          e;
    int            p;
    prev_rdy = '0;
    forever begin
      @(negedge clk);
      if (prev_rdy != '0) begin
        total++;
        if (resp_q.size() == 0) begin
          bad++;
          $display("FAIL resp: grant seen %b but no fetch expected", prev_rdy);
        end else begin
          want = resp_q.pop_front();
          p = 0;
          for (int i = N - 1; i >= 0; i--) if (prev_rdy[i]) p = i;
          if (mem_data[p*MW +: MW] !== want) begin
            bad++;
            $display("FAIL resp: port %0d data=%h expected=%h", p, mem_data[p*MW +: MW], want);
          end
        end
      end
      if (cyc_q.size() != 0) begin
        e = cyc_q.pop_front();
        total++;
        if (mem_ready !== e.rdy) begin
          bad++;
          $display("FAIL ready: got=%b expected=%b at %0t", mem_ready, e.rdy, $time);
        end
        total++;
        if (load_ready !== e.lr) begin
          bad++;
          $display("FAIL load_ready: got=%b expected=%b at %0t", load_ready, e.lr, $time);
        end
        total++;
        if (mem_data !== {N{e.data}}) begin
          bad++;
          $display("FAIL data: got=%h expected=%h on all ports at %0t", mem_data, e.data, $time);
        end
      end
      prev_rdy = mem_ready;
    end
  end

  initial begin
    logic [N-1:0]    pend;
    logic [AW-1:0]   paddr [N];
    logic [N*AW-1:0] av;
    logic            r;
    logic            lv;

    rst        = 1'b1;
    mem_valid  = '0;
    mem_addr   = '0;
    load_valid = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    repeat (2) @(posedge clk);
    step(1'b1, '0, '0, 1'b0, '0, '0);
    step(1'b1, '0, '0, 1'b0, '0, '0);

    // Single fetch
    load(5, 16'hA123);
    step(1'b0, 4'b0001, addrs(5, 0, 0, 0), 1'b0, '0, '0);
    idle(1);

    // All four ports from pointer 0
    step(1'b1, '0, '0, 1'b0, '0, '0);
    for (int k = 0; k < 4; k++) load(k, 16'h100 + k);
    step(1'b0, 4'b1111, addrs(0, 1, 2, 3), 1'b0, '0, '0);
    step(1'b0, 4'b1110, addrs(0, 1, 2, 3), 1'b0, '0, '0);
    step(1'b0, 4'b1100, addrs(0, 1, 2, 3), 1'b0, '0, '0);
    step(1'b0, 4'b1000, addrs(0, 1, 2, 3), 1'b0, '0, '0);
    idle(1);

    // Fairness between ports 1 and 3
    for (int k = 0; k < 8; k++) step(1'b0, 4'b1010, addrs(0, 1, 2, 3), 1'b0, '0, '0);
    idle(1);

    // Load takes priority, then read-after-write
    step(1'b0, 4'b0100, addrs(0, 0, 7, 0), 1'b1, AW'(7), 16'hBEEF);
    step(1'b0, 4'b0100, addrs(0, 0, 7, 0), 1'b0, '0, '0);
    idle(1);

    // Reset right after a grant; RAM survives
    step(1'b0, 4'b0010, addrs(0, 2, 0, 0), 1'b0, '0, '0);
    step(1'b1, 4'b0010, addrs(0, 2, 0, 0), 1'b0, '0, '0);
    step(1'b1, '0, '0, 1'b0, '0, '0);
    step(1'b0, 4'b0001, addrs(5, 0, 0, 0), 1'b0, '0, '0);
    step(1'b0, 4'b1000, addrs(0, 0, 0, 2), 1'b0, '0, '0);

    // Idle hold
    load(9, 16'h1234);
    step(1'b0, 4'b0001, addrs(9, 0, 0, 0), 1'b0, '0, '0);
    idle(10);

    // Random traffic over a preloaded window
    for (int k = 0; k < 64; k++) load(k, int'($urandom_range(0, 16'hFFFF)));
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p]  = 1'b1;
          paddr[p] = AW'($urandom_range(0, 63));
        end
      end
      av = {paddr[3], paddr[2], paddr[1], paddr[0]};
      lv = ($urandom_range(0, 15) == 0);
      r  = ($urandom_range(0, 99) == 0);
      step(r, pend, av, lv, AW'($urandom_range(0, 63)), MW'($urandom_range(0, 16'hFFFF)));
      if (r) pend = '0;
      else if (last_g >= 0) pend[PW'(last_g)] = 1'b0;
    end
    idle(3);

    repeat (2) @(negedge clk);
    total++;
    if (cyc_q.size() != 0 || resp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: cycles left=%0d responses left=%0d expected=0", cyc_q.size(), resp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
